// File: rtl/abr_prim_slicer_stream.sv
// Slices an InW-bit word into OutW-bit slices, LSB first; optional skid via ABR_PRIM_SLICER_STREAM_SKID_EN.
// Latency: slice 0 appears one cycle after the word is accepted. Backpressure: out_ready_i stalls the slice;
// in the base build in_ready_o follows out_ready_i combinationally on the final slice, the skid build registers it.
module abr_prim_slicer_stream #(
    parameter  int InW       = 64,
    parameter  int OutW      = 8,
    localparam int NumSlices = (InW + OutW - 1) / OutW,
    localparam int IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [InW-1:0]    in_data_i,
    input  logic [IdxW:0]     in_len_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OutW-1:0]   out_data_o,
    output logic              out_last_o,
    output logic [IdxW-1:0]   out_idx_o,
    output logic              busy_o
);

    localparam int PadW = NumSlices * OutW;
    localparam int LenW = IdxW + 1;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e            state_q, state_d;
    logic [PadW-1:0]   data_q, data_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              last_q, last_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic              in_ready, accept, is_final;
    logic              load_in, load_skid, park;

    function automatic logic [LenW-1:0] eff_len(input logic [LenW-1:0] l);
        if (l == '0 || l > LenW'(NumSlices)) return LenW'(NumSlices);
        return l;
    endfunction

    assign is_final = (state_q == EMIT) && (({1'b0, sel_q} + LenW'(1)) == len_q);
    assign accept   = in_valid_i & in_ready;

`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
    logic              skid_vld_q, skid_vld_d;
    logic [PadW-1:0]   skid_data_q, skid_data_d;
    logic [LenW-1:0]   skid_len_q, skid_len_d;
    logic              skid_last_q, skid_last_d;

    assign in_ready = ~clear_i & ~skid_vld_q;
`else
    assign in_ready = ~clear_i & ((state_q == IDLE) | (out_ready_i & is_final));
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        last_d    = last_q;
        sel_d     = sel_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        park      = 1'b0;
`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_len_d  = skid_len_q;
        skid_last_d = skid_last_q;
`endif
        if (clear_i) begin
            state_d = IDLE;
            data_d  = '0;
            len_d   = '0;
            last_d  = 1'b0;
            sel_d   = '0;
`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
            skid_vld_d  = 1'b0;
            skid_data_d = '0;
            skid_len_d  = '0;
            skid_last_d = 1'b0;
`endif
        end else if (state_q == IDLE) begin
            load_in = accept;
        end else begin
            if (out_ready_i) begin
                if (!is_final) begin
                    sel_d = sel_q + IdxW'(1);
`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
                end else if (skid_vld_q) begin
                    load_skid  = 1'b1;
                    skid_vld_d = 1'b0;
`endif
                end else if (accept) begin
                    load_in = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            // A word accepted while the word register stays occupied waits in the skid.
            park = accept & ~load_in;
        end

        if (load_in) begin
            state_d = EMIT;
            data_d  = PadW'(in_data_i);
            len_d   = eff_len(in_len_i);
            last_d  = in_last_i;
            sel_d   = '0;
        end
`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
        if (load_skid) begin
            state_d = EMIT;
            data_d  = skid_data_q;
            len_d   = skid_len_q;
            last_d  = skid_last_q;
            sel_d   = '0;
        end
        if (park) begin
            skid_vld_d  = 1'b1;
            skid_data_d = PadW'(in_data_i);
            skid_len_d  = eff_len(in_len_i);
            skid_last_d = in_last_i;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

`ifdef ABR_PRIM_SLICER_STREAM_SKID_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_len_q  <= '0;
            skid_last_q <= 1'b0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_len_q  <= skid_len_d;
            skid_last_q <= skid_last_d;
        end
    end
`endif

    assign in_ready_o  = in_ready;
    assign out_valid_o = (state_q == EMIT);
    assign busy_o      = (state_q == EMIT);
    assign out_data_o  = data_q[32'(sel_q) * OutW +: OutW];
    assign out_idx_o   = sel_q;
    assign out_last_o  = is_final & last_q;

`ifndef SYNTHESIS
    a_params : assert property (@(posedge clk_i) (InW >= 1) && (OutW >= 1));
    a_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !clear_i) |=> $stable(out_data_o));
    a_sel    : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == EMIT) |-> ({1'b0, sel_q} < len_q));
`endif

endmodule
